// File: rtl/fetch_replay_pkg.sv
// common -- shared types for the fetch/replay front end.
//   pc_t    : 32-bit instruction address
//   state_t : fetch FSM states (RUN, MISS_WAIT, EXC)
package common;

   typedef logic [31:0] pc_t;

   typedef enum logic [1:0] {
      RUN,
      MISS_WAIT,
      EXC
   } state_t;

endpackage

// File: rtl/fetch_replay_sat_counter.sv
// sat_counter -- saturating up-counter.
// Ports:
//   clk   : clock
//   clear : synchronous clear (wins over inc)
//   inc   : increment request; ignored once the count is all-ones
//   count : current count, registered
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_replay.sv
// fetch_replay -- instruction fetch PC sequencer with hazard replay,
// I-cache miss wait and I-TLB exception handoff.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   isvalid        : hazard verdict on the instruction fetched last cycle (0 = replay)
//   itlb_miss      : I-TLB miss on the current fetch
//   icache_miss    : I-cache miss on the current fetch
//   icache_ready   : I-cache fill complete
//   branch_taken   : redirect request, branch_target = redirect address
//   stall_ext      : downstream stall, hold PC
//   exc_ack        : exception handler has taken exc_pc
//   fetch_pc/req   : current fetch address and valid
//   exc_valid/pc   : pending I-TLB exception and faulting PC
//   replay_cnt     : saturating count of replays
module fetch_replay
   import common::*;
#(
   parameter pc_t RESET_PC   = 32'h0000_1000,
   parameter pc_t EXC_VECTOR = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        isvalid,
   input  logic        itlb_miss,
   input  logic        icache_miss,
   input  logic        icache_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall_ext,
   input  logic        exc_ack,
   output logic [31:0] fetch_pc,
   output logic        fetch_req,
   output logic        exc_valid,
   output logic [31:0] exc_pc,
   output logic [15:0] replay_cnt
);

   state_t state, state_n;
   pc_t    pc_n;
   pc_t    exc_pc_n;
   pc_t    last_pc, last_pc_n;
   logic   req_n;
   logic   exc_valid_n;
   logic   inflight, inflight_n;
   logic   replay_inc;

   // inflight: an ordinary fetch was issued last cycle, so isvalid carries a
   // real verdict. Cleared after reset, miss/exception exit and redirects.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         fetch_pc  <= RESET_PC;
         fetch_req <= 1'b0;
         exc_valid <= 1'b0;
         exc_pc    <= '0;
         last_pc   <= RESET_PC;
         inflight  <= 1'b0;
      end else begin
         state     <= state_n;
         fetch_pc  <= pc_n;
         fetch_req <= req_n;
         exc_valid <= exc_valid_n;
         exc_pc    <= exc_pc_n;
         last_pc   <= last_pc_n;
         inflight  <= inflight_n;
      end
   end

   always_comb begin
      state_n     = state;
      pc_n        = fetch_pc;
      req_n       = fetch_req;
      exc_valid_n = exc_valid;
      exc_pc_n    = exc_pc;
      last_pc_n   = last_pc;
      inflight_n  = inflight;
      replay_inc  = 1'b0;

      if (fetch_req && !stall_ext) begin
         last_pc_n = fetch_pc;
      end

      unique case (state)
         RUN: begin
            if (!fetch_req) begin
               // Only reachable right after reset: issue RESET_PC.
               if (!stall_ext) begin
                  req_n = 1'b1;
               end
               inflight_n = 1'b0;
            end else if (itlb_miss) begin
               state_n     = EXC;
               exc_valid_n = 1'b1;
               exc_pc_n    = fetch_pc;
               req_n       = 1'b0;
               inflight_n  = 1'b0;
            end else if (icache_miss) begin
               state_n    = MISS_WAIT;
               req_n      = 1'b0;
               inflight_n = 1'b0;
            end else if (branch_taken) begin
               pc_n       = branch_target;
               inflight_n = 1'b0;
            end else if (inflight && !isvalid) begin
               pc_n       = last_pc;
               replay_inc = 1'b1;
               inflight_n = 1'b1;
            end else if (stall_ext) begin
               inflight_n = 1'b1;
            end else begin
               pc_n       = fetch_pc + 32'd4;
               inflight_n = 1'b1;
            end
         end
         MISS_WAIT: begin
            if (icache_ready) begin
               state_n    = RUN;
               req_n      = 1'b1;
               inflight_n = 1'b0;
            end
         end
         EXC: begin
            if (exc_ack) begin
               state_n     = RUN;
               exc_valid_n = 1'b0;
               pc_n        = EXC_VECTOR;
               req_n       = 1'b1;
               inflight_n  = 1'b0;
            end
         end
         default: begin
            state_n = RUN;
         end
      endcase
   end

   sat_counter #(
      .WIDTH(16)
   ) u_replay_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (replay_inc),
      .count (replay_cnt)
   );

endmodule
